// File: rtl/sparse_operand_matcher_stream.sv
// Streams compacted (activation, weight) index pairs of mutually non-zero bitmask positions, LANES per beat.
// Optional SPARSE_MATCHER_DROP_EMPTY_EN: transactions with no matches are absorbed without an output beat.
module sparse_operand_matcher_stream #(
  parameter int BITMASK_LENGTH = 16,
  parameter int INDEX_BITWIDTH = $clog2(BITMASK_LENGTH),
  parameter int COUNT_BITWIDTH = $clog2(BITMASK_LENGTH + 1),
  parameter int LANES          = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            ivalid,
  output logic                            oready,
  input  logic [BITMASK_LENGTH-1:0]       bitmaskW,
  input  logic [BITMASK_LENGTH-1:0]       bitmaskA,
  output logic                            ovalid,
  input  logic                            iready,
  output logic [LANES*INDEX_BITWIDTH-1:0] indexA,
  output logic [LANES*INDEX_BITWIDTH-1:0] indexW,
  output logic [LANES-1:0]                laneValid,
  output logic                            last,
  output logic [COUNT_BITWIDTH-1:0]       pairCount
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state_reg, state_next;
  logic [BITMASK_LENGTH-1:0] match;
  logic [INDEX_BITWIDTH-1:0] slot_a_next [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0] slot_w_next [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0] slot_a_reg  [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0] slot_w_reg  [BITMASK_LENGTH];
  logic [COUNT_BITWIDTH-1:0] run_a, run_w, match_count;
  logic [COUNT_BITWIDTH-1:0] rem_reg, count_reg;
  logic                      handshake, last_beat, accept, load;

  assign match = bitmaskA & bitmaskW;

  // Prefix popcounts walk the masks once; each matched position lands in the next free slot.
  always_comb begin
    run_a       = '0;
    run_w       = '0;
    match_count = '0;
    for (int k = 0; k < BITMASK_LENGTH; k++) begin
      slot_a_next[k] = '0;
      slot_w_next[k] = '0;
    end
    for (int p = 0; p < BITMASK_LENGTH; p++) begin
      if (match[p]) begin
        slot_a_next[match_count[INDEX_BITWIDTH-1:0]] = run_a[INDEX_BITWIDTH-1:0];
        slot_w_next[match_count[INDEX_BITWIDTH-1:0]] = run_w[INDEX_BITWIDTH-1:0];
        match_count = match_count + 1'b1;
      end
      run_a = run_a + COUNT_BITWIDTH'(bitmaskA[p]);
      run_w = run_w + COUNT_BITWIDTH'(bitmaskW[p]);
    end
  end

  assign ovalid    = (state_reg == EMIT);
  assign handshake = ovalid && iready;
  assign last_beat = ovalid && (rem_reg <= COUNT_BITWIDTH'(LANES));
  assign oready    = !reset && ((state_reg == IDLE) || (handshake && last_beat));
  assign accept    = ivalid && oready;

`ifdef SPARSE_MATCHER_DROP_EMPTY_EN
  assign load = accept && (match != '0);
`else
  assign load = accept;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = EMIT;
      EMIT:    if (handshake && last_beat) state_next = load ? EMIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pending pairs shift down by LANES per accepted beat, so lane j always reads slot j.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      count_reg <= '0;
      for (int k = 0; k < BITMASK_LENGTH; k++) begin
        slot_a_reg[k] <= '0;
        slot_w_reg[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (load) begin
        slot_a_reg <= slot_a_next;
        slot_w_reg <= slot_w_next;
        rem_reg    <= match_count;
        count_reg  <= match_count;
      end else if (handshake && !last_beat) begin
        rem_reg <= rem_reg - COUNT_BITWIDTH'(LANES);
        for (int k = 0; k < BITMASK_LENGTH; k++) begin
          if (k + LANES < BITMASK_LENGTH) begin
            slot_a_reg[k] <= slot_a_reg[(k + LANES) % BITMASK_LENGTH];
            slot_w_reg[k] <= slot_w_reg[(k + LANES) % BITMASK_LENGTH];
          end else begin
            slot_a_reg[k] <= '0;
            slot_w_reg[k] <= '0;
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign laneValid[gi] = ovalid && (COUNT_BITWIDTH'(gi) < rem_reg);
      assign indexA[(gi+1)*INDEX_BITWIDTH-1 -: INDEX_BITWIDTH] = laneValid[gi] ? slot_a_reg[gi] : '0;
      assign indexW[(gi+1)*INDEX_BITWIDTH-1 -: INDEX_BITWIDTH] = laneValid[gi] ? slot_w_reg[gi] : '0;
    end
  endgenerate

  assign last      = last_beat;
  assign pairCount = ovalid ? count_reg : '0;

endmodule

// File: tb/tb_sparse_operand_matcher_stream.sv
// Bench for sparse_operand_matcher_stream: vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_sparse_operand_matcher_stream;
  localparam int L  = 16;
  localparam int LN = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ivalid = 1'b0;
  logic        iready = 1'b0;
  logic [15:0] bitmaskW = '0;
  logic [15:0] bitmaskA = '0;
  logic        oready, ovalid, last;
  logic [15:0] indexA, indexW;
  logic [3:0]  laneValid;
  logic [4:0]  pairCount;

  int checks = 0;
  int errors = 0;

  sparse_operand_matcher_stream #(.BITMASK_LENGTH(L), .LANES(LN)) dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
    .bitmaskW(bitmaskW), .bitmaskA(bitmaskA), .ovalid(ovalid), .iready(iready),
    .indexA(indexA), .indexW(indexW), .laneValid(laneValid), .last(last), .pairCount(pairCount)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: pair k is the k-th common set bit; its indices count set bits below it in each mask.
  int exp_n;
  int exp_ia[$];
  int exp_iw[$];
  task automatic model(input logic [15:0] w, input logic [15:0] a);
    logic [15:0] below;
    exp_ia.delete();
    exp_iw.delete();
    for (int p = 0; p < L; p++) begin
      if (w[p] && a[p]) begin
        below = 16'((32'd1 << p) - 1);
        exp_ia.push_back($countones(a & below));
        exp_iw.push_back($countones(w & below));
      end
    end
    exp_n = exp_ia.size();
  endtask

  task automatic check_beat(input int b, input int nb);
    logic [15:0] ia, iw;
    logic [3:0]  lv;
    ia = '0; iw = '0; lv = '0;
    for (int j = 0; j < LN; j++) begin
      if (b * LN + j < exp_n) begin
        ia[j*4 +: 4] = 4'(exp_ia[b*LN+j]);
        iw[j*4 +: 4] = 4'(exp_iw[b*LN+j]);
        lv[j] = 1'b1;
      end
    end
    chk("ovalid", ovalid, 1);
    chk("indexA", indexA, ia);
    chk("indexW", indexW, iw);
    chk("laneValid", laneValid, lv);
    chk("last", last, (b == nb - 1));
    chk("pairCount", pairCount, exp_n);
  endtask

  logic [15:0] first_ia, first_iw;
  logic [3:0]  first_lv;
  logic        first_last;
  logic [4:0]  first_cnt;
  int          obs_beats;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send_txn(input logic [15:0] w, input logic [15:0] a, input int stall);
    int nb, guard;
    model(w, a);
    nb = (exp_n == 0) ? 1 : (exp_n + LN - 1) / LN;
    obs_beats = 0;
    ivalid = 1'b1; bitmaskW = w; bitmaskA = a; iready = 1'b0;
    guard = 0;
    while (!oready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("accept_wait", oready, 1);
    @(posedge clock);
    @(negedge clock);
    ivalid = 1'b0;
`ifdef SPARSE_MATCHER_DROP_EMPTY_EN
    if (exp_n == 0) nb = 0;
`endif
    if (nb == 0) begin
      chk("drop_ovalid", ovalid, 0);
      chk("drop_oready", oready, 1);
    end
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
        iready = 1'b0;
        check_beat(b, nb);
        chk("stall_oready", oready, 0);
        @(negedge clock);
      end
      iready = 1'b1;
      check_beat(b, nb);
      if (b == 0) begin
        first_ia = indexA; first_iw = indexW; first_lv = laneValid;
        first_last = last; first_cnt = pairCount;
      end
      obs_beats++;
      @(posedge clock);
      @(negedge clock);
      iready = 1'b0;
    end
    chk("end_ovalid", ovalid, 0);
    chk("end_oready", oready, 1);
    $display("txn w=%h a=%h pairs=%0d beats=%0d stall=%0d", w, a, exp_n, obs_beats, stall);
  endtask

  typedef struct {
    logic [15:0] w, a, ia0, iw0;
    logic [3:0]  lv0;
    logic        last0;
    int          cnt, beats, stall;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'hFFFF, 16'h00F0, 16'h3210, 16'h7654, 4'hF, 1'b1, 4, 1, 0};
    vecs[1] = '{16'hAAAA, 16'hFFFF, 16'h7531, 16'h3210, 4'hF, 1'b0, 8, 2, 0};
    vecs[2] = '{16'hAAAA, 16'hFFFF, 16'h7531, 16'h3210, 4'hF, 1'b0, 8, 2, 3};
`ifdef SPARSE_MATCHER_DROP_EMPTY_EN
    vecs[3] = '{16'h0F0F, 16'hF0F0, 16'h0000, 16'h0000, 4'h0, 1'b1, 0, 0, 0};
`else
    vecs[3] = '{16'h0F0F, 16'hF0F0, 16'h0000, 16'h0000, 4'h0, 1'b1, 0, 1, 0};
`endif
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h3210, 16'h3210, 4'hF, 1'b0, 16, 4, 0};
    vecs[5] = '{16'h0003, 16'h0001, 16'h0000, 16'h0000, 4'h1, 1'b1, 1, 1, 0};
    vecs[6] = '{16'h8001, 16'h8000, 16'h0000, 16'h0001, 4'h1, 1'b1, 1, 1, 1};

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_oready", oready, 0);
    chk("rst_ovalid", ovalid, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_oready", oready, 1);
    chk("post_rst_ovalid", ovalid, 0);
    chk("post_rst_laneValid", laneValid, 0);
    chk("post_rst_pairCount", pairCount, 0);
    chk("post_rst_last", last, 0);
    chk("post_rst_indexA", indexA, 0);
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      send_txn(vecs[i].w, vecs[i].a, vecs[i].stall);
      chk("tbl_beats", obs_beats, vecs[i].beats);
      if (obs_beats > 0) begin
        chk("tbl_indexA0", first_ia, vecs[i].ia0);
        chk("tbl_indexW0", first_iw, vecs[i].iw0);
        chk("tbl_laneValid0", first_lv, vecs[i].lv0);
        chk("tbl_last0", first_last, vecs[i].last0);
        chk("tbl_pairCount", first_cnt, vecs[i].cnt);
      end
    end

    // Back-to-back: second input accepted in the cycle of the first's last handshake
    ivalid = 1'b1; bitmaskW = 16'hFFFF; bitmaskA = 16'h00F0; iready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bitmaskW = 16'h0003; bitmaskA = 16'h0001;
    chk("b2b_ovalid0", ovalid, 1);
    chk("b2b_last0", last, 1);
    chk("b2b_indexA0", indexA, 16'h3210);
    chk("b2b_oready", oready, 1);
    @(posedge clock);
    @(negedge clock);
    ivalid = 1'b0;
    chk("b2b_ovalid1", ovalid, 1);
    chk("b2b_laneValid1", laneValid, 4'b0001);
    chk("b2b_indexA1", indexA, 0);
    chk("b2b_indexW1", indexW, 0);
    chk("b2b_pairCount1", pairCount, 1);
    @(posedge clock);
    @(negedge clock);
    chk("b2b_idle", ovalid, 0);
    iready = 1'b0;
    $display("txn back-to-back w=ffff/0003 a=00f0/0001");

`ifdef SPARSE_MATCHER_DROP_EMPTY_EN
    // Empty inputs absorbed one per cycle
    ivalid = 1'b1; bitmaskW = 16'h0F0F; bitmaskA = 16'hF0F0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("drop_run_oready", oready, 1);
      chk("drop_run_ovalid", ovalid, 0);
    end
    ivalid = 1'b0;
    $display("txn empty-run w=0f0f a=f0f0 x3");
`endif

    // Reset asserted during beat0 of a two-beat transaction
    ivalid = 1'b1; bitmaskW = 16'hAAAA; bitmaskA = 16'hFFFF; iready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    ivalid = 1'b0;
    chk("mid_rst_pre_ovalid", ovalid, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ovalid", ovalid, 0);
    chk("mid_rst_oready", oready, 0);
    chk("mid_rst_laneValid", laneValid, 0);
    chk("mid_rst_pairCount", pairCount, 0);
    chk("mid_rst_last", last, 0);
    @(negedge clock);
    reset = 1'b0;
    iready = 1'b1;
    #1;
    chk("mid_rst_rel_oready", oready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("mid_rst_no_beat1", ovalid, 0);
    end
    iready = 1'b0;
    $display("txn reset-mid-stream w=aaaa a=ffff");

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rw, ra;
      rw = 16'($urandom);
      ra = 16'($urandom);
      if (i % 3 == 1) rw = rw | 16'($urandom);
      if (i % 5 == 2) ra = ra & 16'($urandom);
      send_txn(rw, ra, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
